// File: rtl/k_low_pass_filter_mc.sv
// Time-multiplexed first-order IIR low-pass filter: one shared datapath, per-channel
// x[n-1]/y[n-1] state, runtime-loadable shift k and per-sample bypass.
module k_low_pass_filter_mc #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 32,
    parameter int NCH       = 4,
    parameter int K_DEFAULT = 26,
    parameter int K_MIN     = 1,
    parameter int K_MAX     = 31,
    localparam int ACC_W    = DATA_W + FRAC_W,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     k_load,
    input  logic [5:0]               k_cfg,
    input  logic                     clr,
    input  logic [CH_W-1:0]          clr_ch,
    input  logic                     bypass,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] y,
    output logic [5:0]               k_active
);

    function automatic logic ch_in_range(input logic [CH_W-1:0] c);
        return 32'(c) < NCH;
    endfunction

    function automatic logic [5:0] k_clamp(input logic [5:0] k);
        if (32'(k) < K_MIN) return 6'(K_MIN);
        if (32'(k) > K_MAX) return 6'(K_MAX);
        return k;
    endfunction

    // Floor rounding: dropping the guard bits of a two's-complement value rounds toward -inf.
    function automatic logic signed [DATA_W-1:0] acc_floor(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1:FRAC_W];
    endfunction

    logic                     vld_p1_q, vld_p1_d;
    logic [CH_W-1:0]          ch_p1_q, ch_p1_d;
    logic signed [DATA_W-1:0] x_p1_q, x_p1_d;
    logic                     byp_p1_q, byp_p1_d;

    logic                     out_valid_q, out_valid_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic [5:0]               k_q, k_d;

    logic signed [ACC_W-1:0]  x1_q [NCH];
    logic signed [ACC_W-1:0]  x1_d [NCH];
    logic signed [ACC_W-1:0]  y1_q [NCH];
    logic signed [ACC_W-1:0]  y1_d [NCH];

    logic signed [ACC_W-1:0]  x_acc, x1_rd, y1_rd, y_new;
    logic signed [ACC_W:0]    sum_w, a_w, b_w, y1_ext, y_sum;

    // ---- S2: filter arithmetic from the S1 registers and the selected channel state ----
    always_comb begin : s2_compute
        x1_rd = '0;
        y1_rd = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(ch_p1_q) == c) begin
                x1_rd = x1_q[c];
                y1_rd = y1_q[c];
            end
        end
        x_acc  = {x_p1_q, {FRAC_W{1'b0}}};
        sum_w  = {x_acc[ACC_W-1], x_acc} + {x1_rd[ACC_W-1], x1_rd};
        y1_ext = {y1_rd[ACC_W-1], y1_rd};
        a_w    = sum_w >>> k_q;
        b_w    = y1_ext >>> (k_q - 6'd1);
        y_sum  = y1_ext + a_w - b_w;
        y_new  = y_sum[ACC_W-1:0];
    end

    always_comb begin : next_state
        vld_p1_d    = in_valid && ch_in_range(in_ch);
        ch_p1_d     = in_ch;
        x_p1_d      = x;
        byp_p1_d    = bypass;
        k_d         = k_load ? k_clamp(k_cfg) : k_q;
        out_valid_d = vld_p1_q;
        out_ch_d    = out_ch_q;
        y_d         = y_q;
        x1_d        = x1_q;
        y1_d        = y1_q;

        if (vld_p1_q) begin
            out_ch_d = ch_p1_q;
            y_d      = byp_p1_q ? x_p1_q : acc_floor(y_new);
            for (int c = 0; c < NCH; c++) begin
                if (32'(ch_p1_q) == c) begin
                    x1_d[c] = x_acc;
                    y1_d[c] = y_new;
                end
            end
        end

        // A clear on the same edge as an update of that channel overrides the state write.
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                if (32'(clr_ch) == c) begin
                    x1_d[c] = '0;
                    y1_d[c] = '0;
                end
            end
        end
    end

    // ---- S1 capture / state and output commit ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q    <= 1'b0;
            ch_p1_q     <= '0;
            x_p1_q      <= '0;
            byp_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            k_q         <= 6'(K_DEFAULT);
            for (int c = 0; c < NCH; c++) begin
                x1_q[c] <= '0;
                y1_q[c] <= '0;
            end
        end else if (enable) begin
            vld_p1_q    <= vld_p1_d;
            ch_p1_q     <= ch_p1_d;
            x_p1_q      <= x_p1_d;
            byp_p1_q    <= byp_p1_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            y_q         <= y_d;
            k_q         <= k_d;
            for (int c = 0; c < NCH; c++) begin
                x1_q[c] <= x1_d[c];
                y1_q[c] <= y1_d[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign y         = y_q;
    assign k_active  = k_q;

endmodule

// File: tb/tb_k_low_pass_filter_mc.sv
// Bench for k_low_pass_filter_mc: directed test-plan scenarios plus randomized traffic
// against a per-channel integer reference of the filter recurrence.
module tb_k_low_pass_filter_mc;
    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 32;
    localparam int NCH       = 4;
    localparam int CH_W      = 2;
    localparam int ACC_W     = DATA_W + FRAC_W;
    localparam int K_DEFAULT = 26;
    localparam int K_MIN     = 1;
    localparam int K_MAX     = 31;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     enable = 1'b0;
    logic                     in_valid = 1'b0;
    logic [CH_W-1:0]          in_ch = '0;
    logic signed [DATA_W-1:0] x = '0;
    logic                     k_load = 1'b0;
    logic [5:0]               k_cfg = '0;
    logic                     clr = 1'b0;
    logic [CH_W-1:0]          clr_ch = '0;
    logic                     bypass = 1'b0;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] y;
    logic [5:0]               k_active;

    k_low_pass_filter_mc #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .NCH(NCH),
        .K_DEFAULT(K_DEFAULT), .K_MIN(K_MIN), .K_MAX(K_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
        .in_ch(in_ch), .x(x), .k_load(k_load), .k_cfg(k_cfg), .clr(clr),
        .clr_ch(clr_ch), .bypass(bypass), .out_valid(out_valid), .out_ch(out_ch),
        .y(y), .k_active(k_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: channel state as 64-bit fixed-point integers with FRAC_W fraction bits.
    longint m_x1 [NCH];
    longint m_y1 [NCH];
    int     m_k;
    bit     pend_v, exp_v;
    int     pend_ch, exp_ch;
    longint pend_y, exp_y;

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_x1[c] = 0;
            m_y1[c] = 0;
        end
        m_k = K_DEFAULT;
        pend_v = 0; pend_ch = 0; pend_y = 0;
        exp_v = 0; exp_ch = 0; exp_y = 0;
    endtask

    // One enabled clock edge: the sample from the previous edge reaches the outputs, then
    // this edge's k load and clear take effect before this edge's sample is filtered.
    task automatic model_edge(input bit v, input int ch, input int xv, input bit kl,
                              input int kc, input bit cl, input int cch, input bit byp);
        longint xa, a, b, yn;
        exp_v = pend_v;
        if (pend_v) begin
            exp_ch = pend_ch;
            exp_y  = pend_y;
        end
        if (kl) m_k = (kc < K_MIN) ? K_MIN : (kc > K_MAX) ? K_MAX : kc;
        if (cl && cch < NCH) begin
            m_x1[cch] = 0;
            m_y1[cch] = 0;
        end
        pend_v = v && (ch < NCH);
        if (pend_v) begin
            xa = longint'(xv) <<< FRAC_W;
            a  = (xa + m_x1[ch]) >>> m_k;
            b  = m_y1[ch] >>> (m_k - 1);
            yn = wrap_acc(m_y1[ch] + a - b);
            m_x1[ch] = xa;
            m_y1[ch] = yn;
            pend_ch  = ch;
            pend_y   = byp ? longint'(xv) : (yn >>> FRAC_W);
        end
    endtask

    task automatic cyc(input bit en, input bit v, input int ch, input int xv,
                       input bit kl = 0, input int kc = 0, input bit cl = 0,
                       input int cch = 0, input bit byp = 0);
        @(negedge clk);
        enable   = en;
        in_valid = v;
        in_ch    = CH_W'(ch);
        x        = DATA_W'(xv);
        k_load   = kl;
        k_cfg    = 6'(kc);
        clr      = cl;
        clr_ch   = CH_W'(cch);
        bypass   = byp;
        @(posedge clk);
        if (en) model_edge(v, ch, xv, kl, kc, cl, cch, byp);
        #1;
        check("out_valid", longint'(out_valid), longint'(exp_v));
        check("out_ch", longint'(out_ch), longint'(exp_ch));
        check("y", longint'(y), exp_y);
        check("k_active", longint'(k_active), longint'(m_k));
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 0; in_valid = 0; k_load = 0; clr = 0; bypass = 0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y", longint'(y), 0);
        check("rst_k_active", longint'(k_active), K_DEFAULT);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_all();
        for (int c = 0; c < NCH; c++) cyc(1, 0, 0, 0, 0, 0, 1, c);
    endtask

    initial begin
        longint ch0_q[$];
        logic signed [DATA_W-1:0] r16;
        model_reset();
        #1 reset_n = 1'b0;
        #10;
        check("init_out_valid", longint'(out_valid), 0);
        check("init_y", longint'(y), 0);
        check("init_k_active", longint'(k_active), K_DEFAULT);
        @(negedge clk);
        reset_n = 1'b1;

        // DC step on ch0 with k=2
        cyc(1, 0, 0, 0, 1, 2);
        cyc(1, 1, 0, 1000);
        cyc(1, 1, 0, 1000);
        check("dc_y0", longint'(y), 250);
        cyc(1, 1, 0, 1000);
        check("dc_y1", longint'(y), 625);
        cyc(1, 0, 0, 0);
        check("dc_y2", longint'(y), 812);
        check("dc_ch", longint'(out_ch), 0);

        // Negative step on ch1
        cyc(1, 1, 1, -1000);
        cyc(1, 1, 1, -1000);
        check("neg_y0", longint'(y), -250);
        cyc(1, 1, 1, -1000);
        check("neg_y1", longint'(y), -625);
        cyc(1, 0, 0, 0);
        check("neg_y2", longint'(y), -813);

        // Round-robin interleave, only ch0 driven
        clear_all();
        for (int i = 0; i < 14; i++) begin
            cyc(1, i < 12, i % 4, (i % 4 == 0) ? 1000 : 0);
            if (out_valid && out_ch == 0) ch0_q.push_back(longint'(y));
        end
        check("rr_count", ch0_q.size(), 3);
        if (ch0_q.size() >= 3) begin
            check("rr_y0", ch0_q[0], 250);
            check("rr_y1", ch0_q[1], 625);
            check("rr_y2", ch0_q[2], 812);
        end

        // Clear coincident with the ch0 state update
        clear_all();
        cyc(1, 1, 0, 1000);
        cyc(1, 1, 0, 1000);
        cyc(1, 1, 0, 1000, 0, 0, 1, 0);
        check("clr_emit", longint'(y), 625);
        cyc(1, 0, 0, 0);
        check("clr_restart", longint'(y), 250);

        // k clamping, and old k used by the sample in flight on the load edge
        cyc(1, 0, 0, 0, 1, 0);
        check("k_min", longint'(k_active), 1);
        cyc(1, 0, 0, 0, 1, 63);
        check("k_max", longint'(k_active), 31);
        cyc(1, 0, 0, 0, 1, 10);
        check("k_mid", longint'(k_active), 10);
        cyc(1, 0, 0, 0, 1, 2, 1, 1);
        cyc(1, 1, 1, 1000);
        cyc(1, 0, 0, 0, 1, 10);
        check("k_old_used", longint'(y), 250);

        // Bypass, then converge and leave bypass with no transient
        cyc(1, 0, 0, 0, 1, 2, 1, 2);
        cyc(1, 1, 3, 1234, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        check("byp_y", longint'(y), 1234);
        for (int i = 0; i < 60; i++) cyc(1, 1, 2, 1000, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 2, 1000);
            check("byp_exit_y", longint'(y), 1000);
        end

        // Stall holds everything
        cyc(1, 1, 0, 500);
        cyc(0, 1, 1, 700, 1, 5, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);

        // Randomized traffic with a reset mid-stream
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            r16 = DATA_W'($urandom);
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                int'($urandom_range(0, NCH - 1)), int'(r16),
                ($urandom_range(0, 19) == 0), int'($urandom_range(0, 63)),
                ($urandom_range(0, 29) == 0), int'($urandom_range(0, NCH - 1)),
                ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/k_low_pass_filter_mc.md
# k_low_pass_filter_mc

Multi-channel, time-multiplexed first-order IIR low-pass filter for the self-trigger chain. One shared datapath with per-channel state registers computes y[n] = y[n-1] + (x[n]+x[n-1])>>k − y[n-1]>>(k−1) for NCH channels. The shift k is runtime-loadable with clamping, and a bypass mode is provided. Arithmetic is width-parametrised and sign-correct, and the block sits between the channel sample mux and the trigger/baseline logic.

## Interface
- DATA_W, 16: sample width, signed two's complement.
- FRAC_W, 32: fractional guard bits; accumulator width ACC_W = DATA_W+FRAC_W.
- NCH, 4: number of channels, ≥1; CH_W = max(1, clog2(NCH)).
- K_DEFAULT, 26: k after reset.
- K_MIN, 1 / K_MAX, 31: clamp range for loaded k; 1 ≤ K_MIN ≤ K_MAX ≤ ACC_W−1.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  pipeline advance; low freezes all registers (state, pipeline, outputs).
- in_valid  in  1  sample strobe.
- in_ch  in  CH_W  channel of sample; values ≥NCH are dropped (no state change, no output).
- x  in  DATA_W  signed input sample.
- k_load  in  1  one-cycle strobe; loads clamped k_cfg into k_active.
- k_cfg  in  6  requested k.
- clr  in  1  clear state of channel clr_ch.
- clr_ch  in  CH_W  channel to clear.
- bypass  in  1  output = delayed input; state still updates.
- out_valid  out  1  output strobe.
- out_ch  out  CH_W  channel of y.
- y  out  DATA_W  signed filtered sample.
- k_active  out  6  k currently applied.

## Operation
- Per-channel state: x_1[c] (ACC_W), y_1[c] (ACC_W). All registers are reset by reset_n low, asynchronously, to 0, except k_active = K_DEFAULT.
- Stage S1, on an edge with enable=1: capture s1_valid = in_valid && in_ch<NCH, s1_ch, s1_x, s1_byp = bypass.
- Stage S2 (compute), combinational from S1 regs, k = k_active:
  - X = s1_x << FRAC_W (ACC_W bits).
  - sum = X + x_1[ch], computed at ACC_W+1 bits with no overflow.
  - a = sum >>> k (arithmetic).
  - b = y_1[ch] >>> (k−1) (arithmetic).
  - Y = y_1[ch] + a − b, truncated to ACC_W.
- On the next enabled edge with s1_valid:
  - x_1[ch] ← X, y_1[ch] ← Y.
  - y ← s1_byp ? s1_x : Y[ACC_W−1:FRAC_W].
  - out_ch ← s1_ch, out_valid ← 1.
- Without s1_valid: out_valid ← 0; y and out_ch hold.
- Rounding is floor (truncation); no saturation is applied because DC gain is 1 with no overshoot.
- k_load on an enabled edge: k_active ← min(max(k_cfg, K_MIN), K_MAX). The new k applies to the S2 computation from the following cycle.
- clr on an enabled edge: x_1[clr_ch] and y_1[clr_ch] ← 0. If clr_ch equals the channel updated on the same edge, clear wins; y/out_valid for that sample are still emitted from the computed value.
- clr_ch ≥ NCH is ignored.
- Bypass switches take effect per sample (sampled into S1); no transient on return because state tracked throughout.

## Timing
- Latency: a sample presented with in_valid at edge E0 gives out_valid/y after edge E0+1 (2 register stages), with enable high at both edges.
- Throughput: one sample per cycle, any channel order, including back-to-back on the same channel. The state write at E0+1 is visible to the S2 read in the next cycle, so no forwarding is needed.
- enable low stalls: S1 contents and outputs hold, and out_valid holds its value.
- k_load coincident with a valid S2 compute: that sample uses the old k.
- Reset mid-stream: everything is cleared asynchronously; the first output after release needs 2 enabled edges.

## Test plan
- DC step, ch0, k loaded =2, x=1000 for 3 samples from reset → y = 250, 625, 812; out_ch=0; each out_valid 2 cycles after input.
- Negative step, ch1, k=2, x=−1000 ×3 → y = −250, −625, −813 (arithmetic shift, floor).
- Interleave ch0..3 round-robin every cycle: ch0 x=1000, others x=0, k=2 → ch0 sequence 250, 625, 812; ch1–3 stay 0.
- k_load with k_cfg=0 → k_active=1; k_cfg=63 → k_active=31; k_cfg=10 → 10. A sample in S2 on the load edge uses the old k.
- Clear/reset: during the ch0 step, clr ch0 on the edge updating ch0 → next ch0 output 250 again. Separately, assert reset_n=0 mid-stream → out_valid=0, y=0, k_active=26 immediately.
- Bypass: x=1234, bypass=1 → y=1234 after 2 cycles. With state converged at 1000 and k=2, x held at 1000 and bypass toggled 1→0 → y=1000, with no transient.
